gt_multi_path_player: RTL and testbench
=======================================

// Module: gt_multi_path_player
// PURPOSE
//  Parametrised multi-channel SRAM-to-GT stream player. Software loads per-channel waveform
//  RAMs through a simple write port. On start, all enabled channels stream their RAM
//  contents to AXI-stream GT lanes, either single-pass or looping. Single clock domain
//  (gt_clk); the register-side CDC lives upstream.
// PARAMETERS
//  NCH  6   number of GT channels
//  DW   32  stream/RAM data width
//  AW   8   RAM address width; depth per channel = 2**AW
//  CW   3   channel-select width; must satisfy 2**CW >= NCH
// PORTS
//  gt_clk     in   1       clock
//  gt_rst     in   1       synchronous reset, active-high
//  wr_en      in   1       RAM write strobe
//  wr_ch      in   CW      target channel of write
//  wr_addr    in   AW      RAM word address
//  wr_data    in   DW      RAM write data
//  cfg_last   in   AW      index of last word to play (length = cfg_last+1)
//  cfg_loop   in   1       1 = wrap to addr 0 after cfg_last, 0 = single pass
//  cfg_chmask in   NCH     channel enable mask
//  start      in   1       start pulse
//  stop       in   1       stop pulse
//  busy       out  1       high when state != IDLE
//  done       out  1       1-cycle pulse on normal single-pass completion
//  m_tdata    out  NCH*DW  per-channel data; channel i at [i*DW +: DW]
//  m_tvalid   out  NCH     per-channel valid
//  m_tready   in   NCH     per-channel ready
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, m_tvalid, m_tdata = 0; read pointers = 0. RAM is not cleared.
//  - Write: wr_en && wr_ch<NCH writes ram[wr_ch][wr_addr] <= wr_data. wr_ch>=NCH is ignored.
//    Writes are accepted in any state. Read/write on the same address in the same cycle is
//    read-first (old data is streamed).
//  - RAM read latency 1 cycle. Each channel has a 2-entry output buffer, so throughput is
//    1 word/cycle/channel under continuous tready with no bubbles.
//  - FSM:
//    - IDLE -> RUN on start && !stop && |cfg_chmask. This latches cfg_last, cfg_loop and
//      cfg_chmask, and sets pointers to 0.
//    - start with mask==0, start && stop, and start outside IDLE are all ignored.
//    - RUN: each enabled channel issues a read when its buffer has space (the count of
//      entries plus in-flight reads is <2). After issuing addr cfg_last, the pointer wraps
//      to 0 if loop; otherwise that channel stops issuing.
//    - RUN -> IDLE with done=1 for one cycle once every enabled channel has issued
//      cfg_last (single pass) and all buffers and in-flight reads are empty.
//    - RUN -> DRAIN on stop. This has priority over a completion in the same cycle.
//    - DRAIN: no new reads. Already-fetched words (at most 2 per channel) are still
//      delivered. Once everything is empty -> IDLE with no done pulse.
//  - Timing: start sampled at cycle 0 -> busy=1 at cycle 1, first m_tvalid at cycle 2.
//  - AXI-S rules: tvalid never drops without a handshake. tdata is held stable while
//    tvalid && !tready. Disabled channels keep tvalid=0.
//  - Channels advance independently under their own tready. Word order per channel is
//    strictly ascending with wrap. No loss or duplication.
//  - gt_rst mid-operation: outputs go to reset values on the next edge. In-flight data is
//    discarded.
// CONFIGURATION
//  GT_TLAST_EN defined: adds port m_tlast (out, NCH). m_tlast[i]=1 with the word read from
//  addr cfg_last, once per pass (every wrap in loop mode). It is held with tdata under
//  backpressure.
//  GT_TLAST_EN undefined: the port is absent and all other behaviour is identical.
// TESTING
//  1. Load ch0 addr0..3 = 0xA0..0xA3; cfg_last=3, loop=0, mask=6'h01; start, tready=1 ->
//     A0..A3 on cycles 2..5, done pulse once, busy=0 afterwards, ch1..5 tvalid=0.
//  2. Same load on ch1 with mask=6'h02; m_tready[1] toggles 1,0,1,0 -> A0..A3 exactly once,
//     in order, tdata stable during stalls.
//  3. ch0={0x11,0x22}, ch2={0x33,0x44}; cfg_last=1, loop=1, mask=6'h05 -> repeating
//     11,22,.. and 33,44,..; after stop, <=2 more words per channel, then tvalid=0, busy=0,
//     no done.
//  4. wr_en with wr_ch=6, addr 0, data 0xDEAD -> every channel's addr0 unchanged on replay.
//  5. gt_rst asserted at the 3rd word of a cfg_last=255 run -> tvalid=0 and busy=0 the next
//     cycle; restart replays from addr 0.
//  6. cfg_last=255, loop=1, GT_TLAST_EN -> m_tlast high only on the addr-255 word, each
//     pass; pointer wraps 255->0 with no bubble.

Source files
------------

// File: rtl/gt_multi_path_player.sv
// gt_multi_path_player: plays per-channel waveform RAMs out to AXI-stream GT lanes.
// Each channel owns a write-loadable RAM, a read pointer and a 2-entry shift buffer
// whose head register drives the lane directly. A shared FSM (IDLE/RUN/DRAIN)
// sequences a run. Optional build macro GT_TLAST_EN adds m_tlast, which marks the
// word read from address cfg_last on every pass.
module gt_multi_path_player #(
    parameter int unsigned NCH = 6,
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 8,
    parameter int unsigned CW  = 3
) (
    input  logic              gt_clk,
    input  logic              gt_rst,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_ch,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [AW-1:0]     cfg_last,
    input  logic              cfg_loop,
    input  logic [NCH-1:0]    cfg_chmask,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [NCH*DW-1:0] m_tdata,
    output logic [NCH-1:0]    m_tvalid,
`ifdef GT_TLAST_EN
    output logic [NCH-1:0]    m_tlast,
`endif
    input  logic [NCH-1:0]    m_tready
);

    localparam int unsigned DEPTH = 1 << AW;
`ifdef GT_TLAST_EN
    localparam int unsigned EW = DW + 1;
`else
    localparam int unsigned EW = DW;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_busy;
    logic            r_done;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    logic [AW-1:0]   r_last;
    logic            r_loop;
    logic [NCH-1:0]  r_mask;

    logic            w_start;
    logic            w_issue_en;
    logic [NCH-1:0]  w_occupied;
    logic [NCH-1:0]  w_fin_ok;
    logic            w_empty;
    logic            w_all_fin;

    assign busy = r_busy;
    assign done = r_done;

    // A start is honoured only from IDLE, without a concurrent stop, and with a non-empty mask.
    assign w_start    = (r_state == S_IDLE) && start && !stop && (|cfg_chmask);
    // Reads are only issued in RUN; a stop in the same cycle already suppresses them.
    assign w_issue_en = (r_state == S_RUN) && !stop;
    assign w_empty    = ~|w_occupied;
    assign w_all_fin  = &w_fin_ok;

    // Run configuration is captured at the accepted start.
    always_ff @(posedge gt_clk) begin
        if (gt_rst) begin
            r_last <= '0;
            r_loop <= 1'b0;
            r_mask <= '0;
        end else if (w_start) begin
            r_last <= cfg_last;
            r_loop <= cfg_loop;
            r_mask <= cfg_chmask;
        end
    end

    // Per-channel RAM, read pointer and 2-entry output buffer.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] r_ram [DEPTH];
        logic [AW-1:0] r_ptr;
        logic          r_fin;
        logic [EW-1:0] r_buf0;
        logic [EW-1:0] r_buf1;
        logic          r_vld0;
        logic          r_vld1;
        logic          w_issue;
        logic          w_pop;
        logic          w_at_last;
        logic [EW-1:0] w_push_data;

        assign w_issue   = w_issue_en && r_mask[i] && !r_fin && !r_vld1;
        assign w_pop     = r_vld0 && m_tready[i];
        assign w_at_last = (r_ptr == r_last);
`ifdef GT_TLAST_EN
        assign w_push_data = {w_at_last, r_ram[r_ptr]};
        assign m_tlast[i]  = r_buf0[DW];
`else
        assign w_push_data = r_ram[r_ptr];
`endif
        assign m_tdata[i*DW +: DW] = r_buf0[DW-1:0];
        assign m_tvalid[i]         = r_vld0;
        assign w_occupied[i]       = r_vld0;
        assign w_fin_ok[i]         = r_fin || !r_mask[i];

        // Waveform RAM write port; nonblocking write keeps same-cycle reads read-first.
        always_ff @(posedge gt_clk) begin
            if (wr_en && (wr_ch == CW'(i))) begin
                r_ram[wr_addr] <= wr_data;
            end
        end

        // Read pointer: wraps after cfg_last; single-pass marks the channel finished.
        always_ff @(posedge gt_clk) begin
            if (gt_rst || w_start) begin
                r_ptr <= '0;
                r_fin <= 1'b0;
            end else if (w_issue) begin
                if (w_at_last) begin
                    r_ptr <= '0;
                    r_fin <= !r_loop;
                end else begin
                    r_ptr <= r_ptr + AW'(1);
                end
            end
        end

        // Shift buffer: head (buf0) is the lane output, buf1 absorbs one word of backpressure.
        always_ff @(posedge gt_clk) begin
            if (gt_rst) begin
                r_buf0 <= '0;
                r_buf1 <= '0;
                r_vld0 <= 1'b0;
                r_vld1 <= 1'b0;
            end else begin
                case ({w_pop, w_issue})
                    2'b10: begin
                        r_buf0 <= r_buf1;
                        r_vld0 <= r_vld1;
                        r_vld1 <= 1'b0;
                    end
                    2'b01: begin
                        if (r_vld0) begin
                            r_buf1 <= w_push_data;
                            r_vld1 <= 1'b1;
                        end else begin
                            r_buf0 <= w_push_data;
                            r_vld0 <= 1'b1;
                        end
                    end
                    2'b11: begin
                        r_buf0 <= w_push_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // FSM state and registered status outputs.
    always_ff @(posedge gt_clk) begin
        if (gt_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // FSM next-state: stop outranks completion in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_all_fin && w_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs: next-cycle busy and the single-pass completion pulse.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (w_state_nxt != S_IDLE) begin
            w_busy_nxt = 1'b1;
        end
        if ((r_state == S_RUN) && !stop && w_all_fin && w_empty) begin
            w_done_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_gt_multi_path_player.sv
// Testbench for gt_multi_path_player: scoreboard of expected per-channel word streams
// built from a RAM model, checked by a negedge monitor. Build with GT_TLAST_EN to
// also check m_tlast.
module tb_gt_multi_path_player;

    localparam int unsigned NCH = 6;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 8;
    localparam int unsigned CW  = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic              gt_clk;
    logic              gt_rst;
    logic              wr_en;
    logic [CW-1:0]     wr_ch;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [AW-1:0]     cfg_last;
    logic              cfg_loop;
    logic [NCH-1:0]    cfg_chmask;
    logic              start;
    logic              stop;
    logic              busy;
    logic              done;
    logic [NCH*DW-1:0] m_tdata;
    logic [NCH-1:0]    m_tvalid;
`ifdef GT_TLAST_EN
    logic [NCH-1:0]    m_tlast;
`endif
    logic [NCH-1:0]    m_tready;

    gt_multi_path_player #(.NCH(NCH), .DW(DW), .AW(AW), .CW(CW)) dut (
        .gt_clk     (gt_clk),
        .gt_rst     (gt_rst),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cfg_last   (cfg_last),
        .cfg_loop   (cfg_loop),
        .cfg_chmask (cfg_chmask),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
`ifdef GT_TLAST_EN
        .m_tlast    (m_tlast),
`endif
        .m_tready   (m_tready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0]  mem [NCH][256];
    exp_t           q_exp [NCH][$];
    logic [NCH-1:0] mask_run = '0;
    bit             stop_seen = 0;
    int             post_stop [NCH];
    int             hs_cnt [NCH];
    int             done_cnt = 0;
    bit             held_v [NCH];
    logic [DW-1:0]  held_d [NCH];
    int             rdy_mode = 0;
    logic           tog = 1'b0;

    initial gt_clk = 1'b0;
    always #5 gt_clk = ~gt_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks AXI-S hold rules.
    always @(negedge gt_clk) begin
        logic [DW-1:0] d;
        exp_t          e;
        if (gt_rst) begin
            for (int c = 0; c < NCH; c++) held_v[c] = 0;
        end else begin
            if (done) done_cnt++;
            chk("disabled_valid", 64'(m_tvalid & ~mask_run), 64'(0));
            for (int c = 0; c < NCH; c++) begin
                d = m_tdata[c*DW +: DW];
                if (held_v[c]) begin
                    chk($sformatf("hold_valid_ch%0d", c), 64'(m_tvalid[c]), 64'(1));
                    chk($sformatf("hold_data_ch%0d", c), 64'(d), 64'(held_d[c]));
                end
                if (m_tvalid[c] && m_tready[c]) begin
                    if (q_exp[c].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_word_ch%0d: got 0x%0h, required no word", c, d);
                    end else begin
                        e = q_exp[c].pop_front();
                        chk($sformatf("data_ch%0d", c), 64'(d), 64'(e.d));
`ifdef GT_TLAST_EN
                        chk($sformatf("tlast_ch%0d", c), 64'(m_tlast[c]), 64'(e.l));
`endif
                    end
                    hs_cnt[c]++;
                    if (stop_seen) post_stop[c]++;
                end
                held_v[c] = m_tvalid[c] && !m_tready[c];
                held_d[c] = d;
            end
        end
    end

    task automatic tick();
        @(posedge gt_clk);
        #1;
        case (rdy_mode)
            0: m_tready = '1;
            1: begin
                tog = ~tog;
                m_tready = {NCH{tog}};
            end
            default: m_tready = NCH'($urandom);
        endcase
    endtask

    task automatic wr(input int ch, input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = CW'(ch);
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (ch < NCH) mem[ch][a] = d;
    endtask

    // Expected stream per enabled channel: addresses 0..last, repeated `passes` times.
    task automatic arm(input logic [NCH-1:0] mask, input int last, input int passes);
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            q_exp[c].delete();
            post_stop[c] = 0;
            hs_cnt[c]    = 0;
            if (mask[c]) begin
                for (int p = 0; p < passes; p++) begin
                    for (int a = 0; a <= last; a++) begin
                        e.d = mem[c][a];
                        e.l = (a == last);
                        q_exp[c].push_back(e);
                    end
                end
            end
        end
        mask_run  = mask;
        stop_seen = 0;
        done_cnt  = 0;
    endtask

    task automatic go(input logic [NCH-1:0] mask, input int last, input bit loop);
        cfg_chmask = mask;
        cfg_last   = AW'(last);
        cfg_loop   = loop;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop_seen = 1;
        stop      = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, 64'(busy), 64'(0));
        tick();
        tick();
    endtask

    task automatic check_empty(input string name);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("%s_left_ch%0d", name, c), 64'(q_exp[c].size()), 64'(0));
    endtask

    task automatic check_drain(input string name);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("%s_post_stop_gt2_ch%0d", name, c), 64'(post_stop[c] > 2), 64'(0));
        chk({name, "_done_after_stop"}, 64'(done_cnt), 64'(0));
        chk({name, "_tvalid_after_drain"}, 64'(m_tvalid), 64'(0));
    endtask

    initial begin
        int bubbles;
        logic [NCH-1:0] rmask;
        int rlast;
        bit rloop;

        gt_rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        cfg_last = '0; cfg_loop = 1'b0; cfg_chmask = '0; start = 1'b0; stop = 1'b0;
        m_tready = '1;
        for (int c = 0; c < NCH; c++) begin
            post_stop[c] = 0; hs_cnt[c] = 0; held_v[c] = 0; held_d[c] = '0;
        end
        tick(); tick();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_tvalid", 64'(m_tvalid), 64'(0));
        chk("reset_tdata", 64'(m_tdata == '0), 64'(1));
        gt_rst = 1'b0;

        // Fill every RAM with random data so the model and the RAMs agree everywhere.
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < 256; a++) wr(c, a, $urandom);

        // Ignored starts: empty mask, and start together with stop.
        cfg_chmask = '0; start = 1'b1; tick(); start = 1'b0; tick();
        chk("start_mask0_busy", 64'(busy), 64'(0));
        cfg_chmask = 6'h01; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
        chk("start_with_stop_busy", 64'(busy), 64'(0));

        // Test 1: ch0 single pass A0..A3 with exact latency.
        for (int a = 0; a < 4; a++) wr(0, a, 32'hA0 + 32'(a));
        arm(6'h01, 3, 1);
        go(6'h01, 3, 1'b0);
        chk("t1_busy_cycle1", 64'(busy), 64'(1));
        chk("t1_tvalid_cycle1", 64'(m_tvalid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t1_tvalid_cycle%0d", k + 2), 64'(m_tvalid[0]), 64'(1));
            chk($sformatf("t1_tdata_cycle%0d", k + 2), 64'(m_tdata[0 +: DW]), 64'(32'hA0 + 32'(k)));
        end
        wait_idle(20, "t1");
        chk("t1_done_count", 64'(done_cnt), 64'(1));
        chk("t1_busy_after", 64'(busy), 64'(0));
        check_empty("t1");

        // Test 2: ch1 with toggling tready.
        for (int a = 0; a < 4; a++) wr(1, a, 32'hA0 + 32'(a));
        tog = 1'b0;
        rdy_mode = 1;
        arm(6'h02, 3, 1);
        go(6'h02, 3, 1'b0);
        wait_idle(40, "t2");
        rdy_mode = 0;
        tick();
        chk("t2_done_count", 64'(done_cnt), 64'(1));
        chk("t2_words", 64'(hs_cnt[1]), 64'(4));
        check_empty("t2");

        // Test 3: loop on ch0/ch2, stray start mid-run, then stop and drain.
        wr(0, 0, 32'h11); wr(0, 1, 32'h22); wr(2, 0, 32'h33); wr(2, 1, 32'h44);
        arm(6'h05, 1, 40);
        go(6'h05, 1, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        cfg_chmask = 6'h3F; start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("t3_streaming_ch0", 64'(hs_cnt[0] > 10), 64'(1));
        chk("t3_streaming_ch2", 64'(hs_cnt[2] > 10), 64'(1));
        do_stop();
        wait_idle(20, "t3");
        check_drain("t3");

        // Test 4: writes to non-existent channels 6 and 7 leave all RAMs untouched.
        wr(6, 0, 32'hDEAD);
        wr(7, 0, 32'hBEEF);
        arm(6'h3F, 1, 1);
        go(6'h3F, 1, 1'b0);
        wait_idle(30, "t4");
        chk("t4_done_count", 64'(done_cnt), 64'(1));
        check_empty("t4");

        // Test 5: reset at the 3rd word of a full-depth run, then replay from address 0.
        arm(6'h01, 255, 1);
        go(6'h01, 255, 1'b0);
        tick(); tick(); tick();
        chk("t5_third_word", 64'(m_tdata[0 +: DW]), 64'(mem[0][2]));
        gt_rst = 1'b1;
        tick();
        chk("t5_tvalid_after_rst", 64'(m_tvalid), 64'(0));
        chk("t5_busy_after_rst", 64'(busy), 64'(0));
        gt_rst = 1'b0;
        tick();
        arm(6'h01, 255, 1);
        go(6'h01, 255, 1'b0);
        wait_idle(400, "t5");
        chk("t5_done_count", 64'(done_cnt), 64'(1));
        check_empty("t5");

        // Test 6: full-depth loop; no bubbles across the 255->0 wrap.
        arm(6'h21, 255, 4);
        go(6'h21, 255, 1'b1);
        tick();
        bubbles = 0;
        for (int k = 0; k < 560; k++) begin
            if (m_tvalid[0] !== 1'b1 || m_tvalid[5] !== 1'b1) bubbles++;
            tick();
        end
        chk("t6_bubbles", 64'(bubbles), 64'(0));
        chk("t6_words_ch5", 64'(hs_cnt[5] >= 560), 64'(1));
        do_stop();
        wait_idle(20, "t6");
        check_drain("t6");

        // Randomized runs: random masks, lengths, data, loop mode and backpressure.
        for (int r = 0; r < 8; r++) begin
            rmask = NCH'($urandom_range(1, 63));
            rlast = $urandom_range(0, 15);
            rloop = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < NCH; c++)
                if (rmask[c])
                    for (int a = 0; a <= rlast; a++) wr(c, a, $urandom);
            rdy_mode = 2;
            arm(rmask, rlast, rloop ? (200 / (rlast + 1) + 2) : 1);
            go(rmask, rlast, rloop);
            if (rloop) begin
                for (int k = 0; k < 60; k++) tick();
                do_stop();
                wait_idle(40, $sformatf("rnd%0d", r));
                check_drain($sformatf("rnd%0d", r));
            end else begin
                wait_idle(500, $sformatf("rnd%0d", r));
                chk($sformatf("rnd%0d_done_count", r), 64'(done_cnt), 64'(1));
                check_empty($sformatf("rnd%0d", r));
            end
            rdy_mode = 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
